// File: rtl/div_reconstruct_checker.sv
// rtl/div_reconstruct_checker.sv - rebuilds n_hat = q*d + r by shift-add and reports error vs n_ref
module div_reconstruct_checker #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   n_ref,
    input  logic [W-1:0]     q,
    input  logic [W-1:0]     d,
    input  logic [W-1:0]     r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   n_hat,
    output logic [2*W:0]     err,
    output logic [2*W-1:0]   abs_err,
    output logic             d_zero,
    output logic             r_ge_d
);

    typedef enum logic [1:0] {IDLE, MUL, FIN, DONE} state_t;

    localparam int CW = $clog2(W + 1);

    state_t          state;
    state_t          state_nx;
    logic [2*W-1:0]  nref_q;
    logic [2*W-1:0]  d_sh;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    q_sh;
    logic [W-1:0]    r_q;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  nh_nx;
    logic [2*W:0]    err_nx;
    logic [2*W:0]    err_neg;
    logic [2*W-1:0]  abs_nx;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; multiply phase has a fixed W-cycle length
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = MUL;
            MUL:     if (cnt == CW'(W - 1)) state_nx = FIN;
            FIN:     state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs depend only on registered state
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Final sum and error; acc + r cannot exceed 2W bits
    always_comb begin
        nh_nx   = acc + {{W{1'b0}}, r_q};
        err_nx  = {1'b0, nref_q} - {1'b0, nh_nx};
        err_neg = -err_nx;
        abs_nx  = err_nx[2*W] ? err_neg[2*W-1:0] : err_nx[2*W-1:0];
    end

    // Operand capture, shift-add multiply and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nref_q  <= '0;
            d_sh    <= '0;
            acc     <= '0;
            q_sh    <= '0;
            r_q     <= '0;
            cnt     <= '0;
            n_hat   <= '0;
            err     <= '0;
            abs_err <= '0;
            d_zero  <= 1'b0;
            r_ge_d  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        nref_q <= n_ref;
                        q_sh   <= q;
                        d_sh   <= {{W{1'b0}}, d};
                        r_q    <= r;
                        acc    <= '0;
                        cnt    <= '0;
                        d_zero <= (d == '0);
                        r_ge_d <= (r >= d);
                    end
                end
                MUL: begin
                    if (q_sh[0]) acc <= acc + d_sh;
                    d_sh <= d_sh << 1;
                    q_sh <= q_sh >> 1;
                    cnt  <= cnt + CW'(1);
                end
                FIN: begin
                    n_hat   <= nh_nx;
                    err     <= err_nx;
                    abs_err <= abs_nx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_reconstruct_checker.sv
// tb/tb_div_reconstruct_checker.sv - self-checking bench for div_reconstruct_checker
module tb_div_reconstruct_checker;

    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [2*W-1:0]   n_ref = '0;
    logic [W-1:0]     q = '0;
    logic [W-1:0]     d = '0;
    logic [W-1:0]     r = '0;
    logic [2*W-1:0]   n_hat;
    logic [2*W:0]     err;
    logic [2*W-1:0]   abs_err;
    logic             d_zero;
    logic             r_ge_d;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] n_ref;
        logic [7:0]  q;
        logic [7:0]  d;
        logic [7:0]  r;
        logic [15:0] e_nhat;
        logic [16:0] e_err;
        logic [15:0] e_abs;
        logic        e_dz;
        logic        e_rge;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    div_reconstruct_checker #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .n_ref(n_ref), .q(q), .d(d), .r(r),
        .out_valid(out_valid), .out_ready(out_ready),
        .n_hat(n_hat), .err(err), .abs_err(abs_err),
        .d_zero(d_zero), .r_ge_d(r_ge_d)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present operands, wait for acceptance, then measure edges until out_valid
    task automatic start_txn(input logic [15:0] a_n, input logic [7:0] a_q, input logic [7:0] a_d,
                             input logic [7:0] a_r, input bit keep_valid, input string tag);
        int t;
        int lat;
        @(negedge clk);
        n_ref = a_n; q = a_q; d = a_d; r = a_r; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " accept_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = keep_valid;
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk({tag, " busy_in_ready"}, {31'b0, in_ready}, 32'd0);
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, 32'd10);
    endtask

    task automatic check_out(input string tag, input logic [15:0] e_nhat, input logic [16:0] e_err,
                             input logic [15:0] e_abs, input logic e_dz, input logic e_rge);
        chk({tag, " n_hat"}, {16'b0, n_hat}, {16'b0, e_nhat});
        chk({tag, " err"}, {15'b0, err}, {15'b0, e_err});
        chk({tag, " abs_err"}, {16'b0, abs_err}, {16'b0, e_abs});
        chk({tag, " d_zero"}, {31'b0, d_zero}, {31'b0, e_dz});
        chk({tag, " r_ge_d"}, {31'b0, r_ge_d}, {31'b0, e_rge});
    endtask

    // Hold the result under backpressure, then release it
    task automatic finish_txn(input int hold, input string tag);
        logic [15:0] s_nhat;
        logic [16:0] s_err;
        s_nhat = n_hat;
        s_err  = err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold_valid"}, {31'b0, out_valid}, 32'd1);
            chk({tag, " hold_in_ready"}, {31'b0, in_ready}, 32'd0);
            chk({tag, " hold_n_hat"}, {16'b0, n_hat}, {16'b0, s_nhat});
            chk({tag, " hold_err"}, {15'b0, err}, {15'b0, s_err});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, " release_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, " release_in_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    // Reference: plain integer arithmetic on the reconstruction identity
    task automatic model_txn(input logic [15:0] a_n, input logic [7:0] a_q, input logic [7:0] a_d,
                             input logic [7:0] a_r, input int hold, input bit keep, input string tag);
        int nh;
        int e;
        int ae;
        logic [16:0] e17;
        nh  = int'(a_q) * int'(a_d) + int'(a_r);
        e   = int'(a_n) - nh;
        ae  = (e < 0) ? -e : e;
        e17 = e[16:0];
        start_txn(a_n, a_q, a_d, a_r, keep, tag);
        check_out(tag, nh[15:0], e17, ae[15:0], a_d == 8'd0, a_r >= a_d);
        finish_txn(hold, tag);
    endtask

    initial begin
        vecs[0] = '{16'd1000, 8'd142, 8'd7,   8'd6,   16'd1000,  17'd0,      16'd0,     1'b0, 1'b0};
        vecs[1] = '{16'd1000, 8'd140, 8'd7,   8'd6,   16'd986,   17'd14,     16'd14,    1'b0, 1'b0};
        vecs[2] = '{16'd0,    8'd255, 8'd255, 8'd255, 16'd65280, 17'h10100,  16'd65280, 1'b0, 1'b1};
        vecs[3] = '{16'd5,    8'd0,   8'd0,   8'd3,   16'd3,     17'd2,      16'd2,     1'b1, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        check_out("reset", 16'd0, 17'd0, 16'd0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            start_txn(vecs[i].n_ref, vecs[i].q, vecs[i].d, vecs[i].r, 1'b0, $sformatf("vec%0d", i));
            check_out($sformatf("vec%0d", i), vecs[i].e_nhat, vecs[i].e_err, vecs[i].e_abs,
                      vecs[i].e_dz, vecs[i].e_rge);
            finish_txn(0, $sformatf("vec%0d", i));
        end

        // Backpressure with a new operand held on the input
        start_txn(16'd1000, 8'd142, 8'd7, 8'd6, 1'b1, "bp");
        check_out("bp", 16'd1000, 17'd0, 16'd0, 1'b0, 1'b0);
        finish_txn(5, "bp");
        model_txn(16'd40000, 8'd200, 8'd199, 8'd10, 0, 1'b0, "bp2");

        // Reset while the multiply is in flight (cnt == 3 at the reset edge)
        @(negedge clk);
        n_ref = 16'd77; q = 8'd9; d = 8'd0; r = 8'd200; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst in_ready", {31'b0, in_ready}, 32'd1);
        check_out("midrst", 16'd0, 17'd0, 16'd0, 1'b0, 1'b0);
        model_txn(16'd1234, 8'd17, 8'd72, 8'd9, 0, 1'b0, "post_rst");

        for (int i = 0; i < 40; i++) begin
            logic [15:0] rn;
            logic [7:0]  rq;
            logic [7:0]  rd;
            logic [7:0]  rr;
            rn = 16'($urandom);
            rq = 8'($urandom);
            rd = 8'($urandom);
            rr = 8'($urandom);
            if (i % 7 == 0) rd = 8'd0;
            if (i % 5 == 0) rn = 16'(int'(rq) * int'(rd) + int'(rr));
            model_txn(rn, rq, rd, rr, int'($urandom_range(0, 3)), 1'($urandom), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
